// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester round-robin arbiter in front of a single-port memory with a
//   combinational read path. One transaction is in flight at a time and walks
//   IDLE -> ACCESS -> RESP, so the memory sees at most one access per 3 cycles.
//
// Ports
//   clk, reset                 sole clock, synchronous active-high reset
//   m<n>_req / m<n>_wr         request and direction (1 = store, 0 = load)
//   m<n>_addr / m<n>_wdata     word address and store data
//   m<n>_storeType/loadType    access-size codes, passed through to memory
//   m<n>_gnt                   request accepted this cycle (IDLE only)
//   m<n>_rvalid / m<n>_rdata   one-cycle response strobe, last load result
//   mem_*                      memory-side command, mem_rdata read back
//   busy                       transaction in flight
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [1:0]        m0_storeType,
  input  logic [2:0]        m0_loadType,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [1:0]        m1_storeType,
  input  logic [2:0]        m1_loadType,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_ce,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_storeType,
  output logic [2:0]        mem_loadType,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_prio;
  logic              r_id;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_storeType;
  logic [2:0]        r_loadType;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_winner;
  logic w_grant;

  // Arbitration: a lone requester wins; on a tie the priority pointer decides.
  // With only m1 requesting, m1_req selects it; with only m0, it selects 0.
  always_comb begin
    w_winner = (m0_req && m1_req) ? r_prio : m1_req;
    w_grant  = (r_state == IDLE) && (m0_req || m1_req) && !reset;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request register, priority pointer and per-requester read-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio      <= 1'b0;
      r_id        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_storeType <= '0;
      r_loadType  <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      if (w_grant) begin
        r_prio      <= ~w_winner;
        r_id        <= w_winner;
        r_wr        <= w_winner ? m1_wr        : m0_wr;
        r_addr      <= w_winner ? m1_addr      : m0_addr;
        r_wdata     <= w_winner ? m1_wdata     : m0_wdata;
        r_storeType <= w_winner ? m1_storeType : m0_storeType;
        r_loadType  <= w_winner ? m1_loadType  : m0_loadType;
      end
      // Loads capture the combinational memory read as ACCESS closes;
      // stores leave the requester's last load result untouched.
      if (r_state == ACCESS && !r_wr) begin
        if (r_id) r_rdata1 <= mem_rdata;
        else      r_rdata0 <= mem_rdata;
      end
    end
  end

  // Outputs: everything is forced low while reset is high, which also keeps a
  // store caught mid-ACCESS from committing at the reset edge.
  always_comb begin
    m0_gnt        = w_grant && !w_winner;
    m1_gnt        = w_grant &&  w_winner;
    mem_ce        = (r_state == ACCESS) && !reset;
    mem_wr_en     = (r_state == ACCESS) && !reset && r_wr;
    mem_addr      = reset ? '0 : r_addr;
    mem_wdata     = reset ? '0 : r_wdata;
    mem_storeType = reset ? '0 : r_storeType;
    mem_loadType  = reset ? '0 : r_loadType;
    m0_rvalid     = (r_state == RESP) && !reset && !r_id;
    m1_rvalid     = (r_state == RESP) && !reset &&  r_id;
    m0_rdata      = reset ? '0 : r_rdata0;
    m1_rdata      = reset ? '0 : r_rdata1;
    busy          = (r_state != IDLE) && !reset;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Drives mem_arbiter with directed scenarios followed by randomized traffic,
//   serves the memory side from a local array, and compares every output each
//   cycle against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [1:0] ST_SB = 2'd0, ST_SH = 2'd1, ST_SW = 2'd2;
  localparam logic [2:0] LT_LB = 3'd0, LT_LW = 3'd2, LT_LBU = 3'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              m0_req, m0_wr, m1_req, m1_wr;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [1:0]        m0_storeType, m1_storeType;
  logic [2:0]        m0_loadType, m1_loadType;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_ce, mem_wr_en, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        mem_storeType;
  logic [2:0]        mem_loadType;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_storeType(m0_storeType), .m0_loadType(m0_loadType),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_storeType(m1_storeType), .m1_loadType(m1_loadType),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_ce(mem_ce), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_storeType(mem_storeType),
    .mem_loadType(mem_loadType), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory seen by the DUT (combinational read, write commits at the edge)
  logic [DATA_W-1:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  // Reference model: one transaction record plus a count of cycles it still
  // occupies after its grant (2 = access cycle, 1 = response cycle).
  typedef struct packed {
    logic              id;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        st;
    logic [2:0]        lt;
  } txn_t;

  txn_t              cur;
  int                busy_left;
  logic              prio;
  logic [DATA_W-1:0] exp_rd [2];
  logic [DATA_W-1:0] ref_mem [256];
  logic              gnt_seen [2];
  int                cyc;
  int                gq_id [$];
  int                gq_cyc [$];
  int                n_checks;
  int                n_errors;

  // Snapshot of DUT outputs taken at the last sampling point
  logic              s_g0, s_g1, s_ce, s_we, s_rv0, s_rv1, s_busy;
  logic [ADDR_W-1:0] s_addr;
  logic [1:0]        s_st;
  logic [2:0]        s_lt;
  logic [DATA_W-1:0] s_rd0, s_rd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input int id, input logic rq, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [1:0] st, input logic [2:0] lt);
    if (id == 0) begin
      m0_req = rq; m0_wr = wr; m0_addr = a; m0_wdata = d; m0_storeType = st; m0_loadType = lt;
    end else begin
      m1_req = rq; m1_wr = wr; m1_addr = a; m1_wdata = d; m1_storeType = st; m1_loadType = lt;
    end
  endtask

  // One clock cycle: sample and check at the falling edge, advance the model,
  // then commit any memory write across the rising edge.
  task automatic tick();
    logic              g, win, rv, e_ce;
    logic              do_wr;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    @(negedge clk);
    g   = !reset && busy_left == 0 && (m0_req || m1_req);
    win = (m0_req && m1_req) ? prio : m1_req;
    rv  = !reset && busy_left == 1;
    e_ce = !reset && busy_left == 2;
    check("gnt0", m0_gnt, g && !win);
    check("gnt1", m1_gnt, g && win);
    check("gnt_both", m0_gnt && m1_gnt, 0);
    check("mem_ce", mem_ce, e_ce);
    check("mem_wr_en", mem_wr_en, e_ce && cur.wr);
    check("mem_addr", mem_addr, reset ? '0 : cur.addr);
    check("mem_wdata", mem_wdata, reset ? '0 : cur.wdata);
    check("mem_st", mem_storeType, reset ? '0 : cur.st);
    check("mem_lt", mem_loadType, reset ? '0 : cur.lt);
    check("rvalid0", m0_rvalid, rv && cur.id == 1'b0);
    check("rvalid1", m1_rvalid, rv && cur.id == 1'b1);
    check("rdata0", m0_rdata, reset ? '0 : exp_rd[0]);
    check("rdata1", m1_rdata, reset ? '0 : exp_rd[1]);
    check("busy", busy, !reset && busy_left != 0);
    s_g0 = m0_gnt; s_g1 = m1_gnt; s_ce = mem_ce; s_we = mem_wr_en; s_busy = busy;
    s_addr = mem_addr; s_st = mem_storeType; s_lt = mem_loadType;
    s_rv0 = m0_rvalid; s_rv1 = m1_rvalid; s_rd0 = m0_rdata; s_rd1 = m1_rdata;
    if (m0_gnt) begin gq_id.push_back(0); gq_cyc.push_back(cyc); end
    if (m1_gnt) begin gq_id.push_back(1); gq_cyc.push_back(cyc); end
    gnt_seen[0] = g && !win;
    gnt_seen[1] = g && win;
    do_wr = mem_ce && mem_wr_en; wa = mem_addr; wd = mem_wdata;
    if (reset) begin
      busy_left = 0; prio = 1'b0; cur = '0; exp_rd[0] = '0; exp_rd[1] = '0;
    end else if (busy_left == 2) begin
      if (cur.wr) ref_mem[cur.addr] = cur.wdata;
      else        exp_rd[cur.id] = ref_mem[cur.addr];
      busy_left = 1;
    end else if (busy_left == 1) begin
      busy_left = 0;
    end else if (g) begin
      if (win) cur = '{id: 1'b1, wr: m1_wr, addr: m1_addr, wdata: m1_wdata, st: m1_storeType, lt: m1_loadType};
      else     cur = '{id: 1'b0, wr: m0_wr, addr: m0_addr, wdata: m0_wdata, st: m0_storeType, lt: m0_loadType};
      prio = !win;
      busy_left = 2;
    end
    @(posedge clk);
    if (do_wr) mem[wa] = wd;
    cyc++;
    #1;
  endtask

  // Raise a request, hold it until the grant cycle, then drop it.
  task automatic do_req(input int id, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [1:0] st, input logic [2:0] lt);
    int k;
    drive(id, 1'b1, wr, a, d, st, lt);
    k = 0;
    do begin
      tick();
      k++;
    end while (!gnt_seen[id] && k < 20);
    check("gnt_wait", gnt_seen[id], 1);
    drive(id, 1'b0, wr, a, d, st, lt);
  endtask

  task automatic set_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] v, saved1, expv;
    int g1_before;
    bit act [2];
    n_checks = 0; n_errors = 0; cyc = 0;
    busy_left = 0; prio = 1'b0; cur = '0; exp_rd[0] = '0; exp_rd[1] = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0, '0);
    // Reset state, with a request present to show gnt is held off
    tick();
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    check("rst_busy", s_busy, 0);
    check("rst_gnt", s_g0 | s_g1, 0);

    // Continuous dual requests straight out of reset alternate 0,1,0,1
    reset = 1'b0;
    gq_id.delete(); gq_cyc.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      for (int n = 0; n < 2; n++)
        if (gnt_seen[n])
          drive(n, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(32, 63)), $urandom,
                ST_SW, LT_LW);
    end
    check("rr_count", gq_id.size(), 4);
    for (int k = 0; k < gq_id.size() && k < 4; k++) begin
      check("rr_order", gq_id[k], k % 2);
      if (k > 0) check("rr_gap", gq_cyc[k] - gq_cyc[k-1], 3);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick(); tick();

    // Single load
    set_word(8'h10, 32'hDEADBEEF);
    do_req(0, 1'b0, 8'h10, '0, ST_SW, LT_LW);
    tick();
    check("ld_ce", s_ce, 1);
    check("ld_we", s_we, 0);
    check("ld_addr", s_addr, 8'h10);
    tick();
    check("ld_rvalid", s_rv0, 1);
    check("ld_rdata", s_rd0, 32'hDEADBEEF);

    // Store by m1, readback by m0
    saved1 = exp_rd[1];
    do_req(1, 1'b1, 8'h04, 32'h12345678, ST_SW, LT_LW);
    tick();
    check("st_we", s_we, 1);
    check("st_type", s_st, ST_SW);
    check("st_addr", s_addr, 8'h04);
    tick();
    check("st_rvalid", s_rv1, 1);
    check("st_rdata1", s_rd1, saved1);
    do_req(0, 1'b0, 8'h04, '0, ST_SW, LT_LW);
    tick(); tick();
    check("st_readback", s_rd0, 32'h12345678);

    // Reset during ACCESS abandons a store
    do_req(0, 1'b1, 8'h20, 32'h13579BDF, ST_SW, LT_LW);
    tick(); tick();
    do_req(0, 1'b1, 8'h20, 32'hAAAA5555, ST_SW, LT_LW);
    reset = 1'b1;
    tick();
    check("rst_acc_we", s_we, 0);
    reset = 1'b0;
    tick();
    check("rst_acc_rvalid", s_rv0 | s_rv1, 0);
    check("rst_acc_busy", s_busy, 0);
    do_req(0, 1'b0, 8'h20, '0, ST_SW, LT_LW);
    tick(); tick();
    check("rst_acc_prior", s_rd0, 32'h13579BDF);

    // m1 request withdrawn while busy: no grant, pointer still favours m1
    g1_before = 0;
    do_req(0, 1'b0, 8'h30, '0, ST_SW, LT_LW);
    drive(1, 1'b1, 1'b1, 8'h31, 32'hCAFEF00D, ST_SW, LT_LW);
    tick();
    g1_before += int'(s_g1);
    m1_req = 1'b0;
    tick();
    g1_before += int'(s_g1);
    tick();
    g1_before += int'(s_g1);
    check("wd_no_gnt", g1_before, 0);
    check("wd_no_access", s_ce, 0);
    drive(0, 1'b1, 1'b0, 8'h32, '0, ST_SW, LT_LW);
    drive(1, 1'b1, 1'b0, 8'h33, '0, ST_SW, LT_LW);
    tick();
    check("wd_prio_m1", s_g1, 1);
    check("wd_prio_m0", s_g0, 0);
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();

    // loadType pass-through
    set_word(8'h08, 32'h000000A5);
    expv = 32'h000000A5;
    do_req(0, 1'b0, 8'h08, '0, ST_SB, LT_LBU);
    tick();
    check("lbu_type", s_lt, LT_LBU);
    tick();
    check("lbu_rdata", s_rd0, expv);

    // Randomized traffic with occasional withdrawals and reset pulses
    act[0] = 0; act[1] = 0;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && $urandom_range(0, 2) == 0) begin
          act[n] = 1;
          drive(n, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                2'($urandom_range(0, 2)), 3'($urandom_range(0, 4)));
        end else if (act[n] && busy_left != 0 && $urandom_range(0, 9) == 0) begin
          act[n] = 0;
          if (n == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
      end
      tick();
      for (int n = 0; n < 2; n++)
        if (gnt_seen[n]) begin
          act[n] = 0;
          if (n == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
